imem_shift_loader: RTL
======================

IMEM_SHIFT_LOADER -- requirements
Module: imem_shift_loader

Interface
REQ-001 SHALL expose parameters: n = 32, instruction width; DEPTH = 256, words of storage; AW = 8, word-index width (log2 DEPTH).
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_start  in  1  single-cycle pulse that begins a program load.
- num_words  in  AW+1  word count for the load, sampled with load_start.
- ser_in  in  1  serial program bit, MSB of each word first.
- ser_valid  in  1  ser_in is valid this cycle.
- pc_to_imem  in  n  byte address from the core.
- imem_out  out  n  instruction returned to the core.
- shift_done  out  1  load complete; core may execute.
- busy  out  1  load in progress.
- load_err  out  1  one-cycle pulse: load request rejected.

Function
REQ-003 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-004 IDLE + load_start + 1 <= num_words <= DEPTH: SHALL latch num_words, clear bit_cnt/word_cnt/shreg, next SHIFT.
REQ-005 IDLE + load_start with num_words = 0 or > DEPTH: SHALL pulse load_err for 1 cycle and remain IDLE.
REQ-006 SHIFT + ser_valid: SHALL set shreg <= {shreg[n-2:0], ser_in} and bit_cnt <= bit_cnt + 1 (5-bit, wraps 31->0).
REQ-007 SHIFT + ser_valid + bit_cnt = 31: SHALL write {shreg[n-2:0], ser_in} to mem[word_cnt] on the same edge and increment word_cnt.
REQ-008 Write of word index num_words-1: SHALL transition to DONE on the same edge.
REQ-009 ser_valid low: SHALL hold all counters and shreg.
REQ-010 ser_valid in IDLE or DONE: SHALL be ignored.
REQ-011 load_start in SHIFT: SHALL be ignored.
REQ-012 load_start in DONE: SHALL be treated as in IDLE (REQ-004/005).
- Valid request: shift_done deasserts the next cycle and memory is overwritten progressively.
- Rejected request: remain in DONE with shift_done held high.
REQ-013 Output decode:
- busy = (state == SHIFT).
- shift_done = (state == DONE).
- Both are registered state decodes.
REQ-014 imem_out SHALL be combinational, with zero-cycle latency from pc_to_imem, and SHALL equal:
- mem[pc_to_imem[AW+1:2]] when state == DONE, pc_to_imem[n-1:AW+2] == 0 and the index < the latched num_words;
- otherwise NOP 32'h0000_0013.
REQ-015 pc_to_imem[1:0] SHALL be ignored.
REQ-016 A write and a core read to the same index never coincide, because reads are NOP-gated outside DONE.

Reset
REQ-017 rst low SHALL immediately force state IDLE and clear bit_cnt, word_cnt, shreg, the latched count and load_err.
- Resulting outputs: shift_done = 0, busy = 0, imem_out = NOP.
REQ-018 Reset mid-load SHALL abandon the partial word; memory contents are not cleared; a new load_start is required.
REQ-019 Reset deassertion SHALL take effect on the first clk edge after rst rises; no spurious load_err on exit.

Structure
REQ-020 Package imem_loader_pkg SHALL hold:
- state encoding (IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2);
- NOP constant 32'h0000_0013;
- DEPTH/AW defaults.
REQ-021 Storage SHALL be sub-module imem_ram: DEPTH x n, synchronous write, asynchronous read, no reset.
REQ-022 The FSM, counters and shift register SHALL reside in imem_shift_loader.

Verification
REQ-023 Reset, then load_start with num_words = 2, serially shifting 32'h0000_0093 then 32'h0010_0113:
- shift_done rises on the cycle after the 64th valid bit;
- pc_to_imem = 0 -> 32'h0000_0093;
- pc_to_imem = 4 -> 32'h0010_0113;
- pc_to_imem = 8 -> 32'h0000_0013.
REQ-024 Gaps in ser_valid: 32'hDEAD_BEEF shifted with ser_valid low on every third cycle -> mem[0] = 32'hDEAD_BEEF and bit_cnt is unaffected by the gaps.
REQ-025 Rejected requests: num_words = 0, then 257 -> load_err pulses once per request, state stays IDLE, busy = 0.
REQ-026 Reset mid-load: rst low after 40 bits of a 2-word load -> shift_done = 0 and busy = 0 immediately.
- A new 1-word load of 32'h1234_5678 then gives imem_out = 32'h1234_5678 at pc_to_imem = 0.
REQ-027 Reload and guard checks:
- load_start in DONE -> shift_done falls the next cycle and imem_out = NOP until the reload completes.
- load_start issued mid-SHIFT -> no effect.
- pc_to_imem = 32'h0000_0400 in DONE -> NOP.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the serial instruction-memory loader.
// State encoding, the NOP returned on gated reads, and default geometry.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam int          DEPTH_DEF = 256;
  localparam int          AW_DEF    = 8;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x n instruction storage: synchronous write, asynchronous read, no reset.
// Read data follows rd_idx combinationally; writes land on the rising edge.
module imem_ram #(
  parameter int n     = 32,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          wr_vld,
  input  logic [AW-1:0] wr_idx,
  input  logic [n-1:0]  wr_dat,
  input  logic [AW-1:0] rd_idx,
  output logic [n-1:0]  rd_dat
);

  logic [n-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_vld) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/imem_shift_loader.sv
// Loads a program bit-serially (MSB first) into imem_ram, then serves core fetches.
// Fetch path is zero-cycle combinational; ser_valid low simply stalls the shifter.
module imem_shift_loader
  import imem_loader_pkg::*;
#(
  parameter int n     = 32,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [AW:0]   num_words,
  input  logic          ser_in,
  input  logic          ser_valid,
  input  logic [n-1:0]  pc_to_imem,
  output logic [n-1:0]  imem_out,
  output logic          shift_done,
  output logic          busy,
  output logic          load_err
);

  localparam int BW = $clog2(n);

  state_t        state_q,    state_d;
  logic [BW-1:0] bit_cnt_q,  bit_cnt_d;
  logic [AW-1:0] word_cnt_q, word_cnt_d;
  logic [n-1:0]  shreg_q,    shreg_d;
  logic [AW:0]   nwords_q,   nwords_d;
  logic          load_err_q, load_err_d;

  logic          wr_vld;
  logic [n-1:0]  shift_word;
  logic          req_ok;
  logic [AW-1:0] rd_idx;
  logic [n-1:0]  rd_dat;
  logic          pc_hi_zero;
  logic          unused_pc_lsbs;

  assign shift_word = {shreg_q[n-2:0], ser_in};
  assign req_ok     = (num_words != '0) && (num_words <= (AW+1)'(DEPTH));

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shreg_d    = shreg_q;
    nwords_d   = nwords_q;
    load_err_d = 1'b0;
    wr_vld     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (load_start) begin
          if (req_ok) begin
            nwords_d   = num_words;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            shreg_d    = '0;
            state_d    = SHIFT;
          end else begin
            load_err_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (ser_valid) begin
          shreg_d   = shift_word;
          bit_cnt_d = bit_cnt_q + BW'(1);
          // Last bit of a word: the completed word is written on this same edge.
          if (bit_cnt_q == BW'(n-1)) begin
            wr_vld     = 1'b1;
            word_cnt_d = word_cnt_q + AW'(1);
            if ({1'b0, word_cnt_q} == nwords_q - (AW+1)'(1)) begin
              state_d = DONE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shreg_q    <= '0;
      nwords_q   <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      shreg_q    <= shreg_d;
      nwords_q   <= nwords_d;
      load_err_q <= load_err_d;
    end
  end

  imem_ram #(
    .n     (n),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk    (clk),
    .wr_vld (wr_vld),
    .wr_idx (word_cnt_q),
    .wr_dat (shift_word),
    .rd_idx (rd_idx),
    .rd_dat (rd_dat)
  );

  // Byte address in, word index out; the two byte-lane bits carry no meaning here.
  assign rd_idx         = pc_to_imem[AW+1:2];
  assign pc_hi_zero     = (pc_to_imem[n-1:AW+2] == '0);
  assign unused_pc_lsbs = ^pc_to_imem[1:0];

  assign imem_out   = ((state_q == DONE) && pc_hi_zero && ({1'b0, rd_idx} < nwords_q))
                      ? rd_dat : n'(NOP);
  assign busy       = (state_q == SHIFT);
  assign shift_done = (state_q == DONE);
  assign load_err   = load_err_q;

endmodule
